// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one RAM2 port, with a hang watchdog that completes stuck transactions.
// Optional `ARB_ROUND_ROBIN_EN: alternate tie winners; otherwise master 0 always wins ties.
module mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   // master 0 (cpu)
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_we,
   input  logic          m0_re,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ready,
   // master 1 (dma / debug loader)
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_we,
   input  logic          m1_re,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ready,
   // shared RAM2 port
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   // status
   output logic [1:0]    grant,
   output logic          timeout_flag
);

   // Handshake: a master holds re/we and its addr/wdata until it samples its ready high,
   // then drops (or replaces) the request on that same edge; ready is a one-cycle pulse.

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant_nxt;
   logic [CW-1:0] count;
   logic          req0, req1;
   logic          tie_pick1;
   logic          wd_fire;
   logic          done;
   logic          busy;

   assign req0 = m0_re | m0_we;
   assign req1 = m1_re | m1_we;
   assign busy = (state == BUSY);

   // A real mem_ready in the deadline cycle wins over the watchdog.
   assign wd_fire = (TIMEOUT != 0) && busy && (count == CW'(TIMEOUT)) && !mem_ready;
   assign done    = busy && (mem_ready || wd_fire);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_winner;

   always_ff @(posedge clk) begin
      if (!rst)
         last_winner <= 1'b1;
      else if (done)
         last_winner <= grant[1];
   end

   assign tie_pick1 = ~last_winner;
`else
   assign tie_pick1 = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = BUSY;
               if (req0 && req1)
                  grant_nxt = tie_pick1 ? 2'b10 : 2'b01;
               else if (req1)
                  grant_nxt = 2'b10;
               else
                  grant_nxt = 2'b01;
            end
         end
         BUSY: begin
            if (done) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         grant        <= 2'b00;
         count        <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (busy && !done) begin
            if (count != '1)
               count <= count + 1'b1;
         end else begin
            count <= '0;
         end
         if (wd_fire)
            timeout_flag <= 1'b1;
      end
   end

   // Address/data follow master 0 while idle so the bus never floats.
   always_comb begin
      mem_addr  = grant[1] ? m1_addr  : m0_addr;
      mem_wdata = grant[1] ? m1_wdata : m0_wdata;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (busy && !wd_fire) begin
         mem_we = grant[1] ? m1_we : m0_we;
         mem_re = grant[1] ? m1_re : m0_re;
      end
   end

   assign m0_ready = done & grant[0];
   assign m1_ready = done & grant[1];
   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM2 model and per-master read-data scoreboards.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 4;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_addr = '0, m1_addr = '0, mem_addr;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, mem_wdata;
  logic          m0_we = 1'b0, m0_re = 1'b0, m1_we = 1'b0, m1_re = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_rdata;
  logic          m0_ready, m1_ready, mem_we, mem_re, mem_ready;
  logic [1:0]    grant;
  logic          timeout_flag;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_re(m0_re),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_re(m1_re),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .timeout_flag(timeout_flag)
  );

  // RAM2 model: ready pulses ram_lat+1 cycles after a request is first seen
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int   ram_lat = 1;
  bit   ram_dead = 1'b0;
  logic spurious = 1'b0;
  logic ram_rdy;
  int   ram_cnt;
  assign mem_ready = ram_rdy | spurious;

  always @(posedge clk) begin
    if (!rst) begin
      ram_rdy <= 1'b0;
      ram_cnt <= 0;
    end else begin
      ram_rdy <= 1'b0;
      if ((mem_re || mem_we) && !ram_rdy && !ram_dead) begin
        if (ram_cnt >= ram_lat) begin
          ram_rdy <= 1'b1;
          ram_cnt <= 0;
          if (mem_we) ram[mem_addr] <= mem_wdata;
          else        mem_rdata <= ram[mem_addr];
        end else begin
          ram_cnt <= ram_cnt + 1;
        end
      end else if (!(mem_re || mem_we)) begin
        ram_cnt <= 0;
      end
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completed reads (real mem_ready, request still held) pop the master's expected queue.
  always @(negedge clk) begin
    if (m0_ready) rdy0_cnt++;
    if (m1_ready) rdy1_cnt++;
    if (m0_ready && m0_re && mem_ready) begin
      check("sb0_pending", exp_q0.size() > 0, 1);
      if (exp_q0.size() > 0) check("sb0_rdata", m0_rdata, exp_q0.pop_front());
    end
    if (m1_ready && m1_re && mem_ready) begin
      check("sb1_pending", exp_q1.size() > 0, 1);
      if (exp_q1.size() > 0) check("sb1_rdata", m1_rdata, exp_q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed time %0t required finish before it", $time);
    $fatal(1, "bench did not finish");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic drive(input int m, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit expect_data);
    if (m == 0) begin
      m0_addr = a; m0_wdata = d; m0_we = wr; m0_re = !wr;
    end else begin
      m1_addr = a; m1_wdata = d; m1_we = wr; m1_re = !wr;
    end
    if (wr) shadow[a] = d;
    else if (expect_data) begin
      if (m == 0) exp_q0.push_back(shadow[a]);
      else        exp_q1.push_back(shadow[a]);
    end
  endtask

  task automatic release_m(input int m);
    if (m == 0) begin m0_re = 1'b0; m0_we = 1'b0; end
    else        begin m1_re = 1'b0; m1_we = 1'b0; end
  endtask

  task automatic wait_ready(input int m, input int budget, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles <= budget) begin
      if ((m == 0) ? m0_ready : m1_ready) got = 1'b1;
      else begin
        step();
        cycles++;
      end
    end
  endtask

  int  cyc;
  bit  got;
  int  r0, r1;
  int  lw;
  logic [1:0] expg;
  logic [AW-1:0] a0, a1;

  initial begin
    ram[16'h0010] = 16'hBEEF; shadow[16'h0010] = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      ram[16'h0100 + i] = 16'($urandom_range(0, 16'hFFFF)); shadow[16'h0100 + i] = ram[16'h0100 + i];
      ram[16'h0200 + i] = 16'($urandom_range(0, 16'hFFFF)); shadow[16'h0200 + i] = ram[16'h0200 + i];
    end

    // reset state
    step(); step(); step();
    check("rst_grant", grant, 2'b00);
    check("rst_tflag", timeout_flag, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_m0_ready", m0_ready, 1'b0);
    check("rst_m1_ready", m1_ready, 1'b0);
    rst = 1'b1;

    // single read by m0
    r0 = rdy0_cnt; r1 = rdy1_cnt;
    drive(0, 1'b0, 16'h0010, '0, 1'b1);
    step();
    check("rd_grant", grant, 2'b01);
    check("rd_mem_re", mem_re, 1'b1);
    check("rd_mem_addr", mem_addr, 16'h0010);
    wait_ready(0, 20, cyc, got);
    check("rd_done", got, 1'b1);
    check("rd_latency", cyc, ram_lat + 1);
    step();
    release_m(0);
    check("rd_idle_grant", grant, 2'b00);
    check("rd_one_pulse", m0_ready, 1'b0);
    check("rd_m0_pulses", rdy0_cnt - r0, 1);
    check("rd_m1_pulses", rdy1_cnt - r1, 0);

    // m1 write then m0 read back
    drive(1, 1'b1, 16'hCFF0, 16'h1234, 1'b0);
    step();
    check("wr_grant", grant, 2'b10);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_wdata", mem_wdata, 16'h1234);
    check("wr_mem_addr", mem_addr, 16'hCFF0);
    wait_ready(1, 20, cyc, got);
    check("wr_done", got, 1'b1);
    step();
    release_m(1);
    check("wr_idle_grant", grant, 2'b00);
    drive(0, 1'b0, 16'hCFF0, '0, 1'b1);
    step();
    check("rb_grant", grant, 2'b01);
    wait_ready(0, 20, cyc, got);
    check("rb_done", got, 1'b1);
    step();
    release_m(0);

    // simultaneous continuous reads: 4 transactions
    do_reset();
    r1 = rdy1_cnt;
    lw = 1;
    a0 = 16'h0100; a1 = 16'h0200;
    drive(0, 1'b0, a0, '0, 1'b1);
    drive(1, 1'b0, a1, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expg = (lw == 1) ? 2'b01 : 2'b10;
      lw = (expg == 2'b10) ? 1 : 0;
`else
      expg = 2'b01;
`endif
      step();
      check("tie_grant", grant, expg);
      wait_ready(expg[1] ? 1 : 0, 20, cyc, got);
      check("tie_done", got, 1'b1);
      step();
      if (k == 3) release_m(expg[1] ? 1 : 0);
      else if (expg[1]) begin a1 = a1 + 1'b1; drive(1, 1'b0, a1, '0, 1'b1); end
      else begin a0 = a0 + 1'b1; drive(0, 1'b0, a0, '0, 1'b1); end
    end
    if (m0_re) begin release_m(0); void'(exp_q0.pop_back()); end
    if (m1_re) begin release_m(1); void'(exp_q1.pop_back()); end
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_m1_pulses", rdy1_cnt - r1, 2);
`else
    check("tie_m1_pulses", rdy1_cnt - r1, 0);
`endif
    step();
    check("tie_idle_grant", grant, 2'b00);

    // mem_ready arrives in the same cycle as the watchdog deadline
    do_reset();
    ram_lat = 3;
    drive(0, 1'b0, 16'h0010, '0, 1'b1);
    step();
    wait_ready(0, 20, cyc, got);
    check("edge_done", got, 1'b1);
    check("edge_latency", cyc, TIMEOUT);
    step();
    release_m(0);
    check("edge_tflag", timeout_flag, 1'b0);
    ram_lat = 1;

    // watchdog abort with a RAM that never answers
    ram_dead = 1'b1;
    r0 = rdy0_cnt;
    drive(0, 1'b0, 16'h0010, '0, 1'b0);
    step();
    check("wd_grant", grant, 2'b01);
    wait_ready(0, 20, cyc, got);
    check("wd_done", got, 1'b1);
    check("wd_latency", cyc, TIMEOUT);
    check("wd_mem_re", mem_re, 1'b0);
    step();
    release_m(0);
    check("wd_tflag", timeout_flag, 1'b1);
    check("wd_idle_grant", grant, 2'b00);
    check("wd_m0_pulses", rdy0_cnt - r0, 1);
    ram_dead = 1'b0;
    drive(1, 1'b0, 16'hCFF0, '0, 1'b1);
    step();
    check("post_wd_grant", grant, 2'b10);
    wait_ready(1, 20, cyc, got);
    check("post_wd_done", got, 1'b1);
    check("post_wd_latency", cyc, ram_lat + 1);
    step();
    release_m(1);
    check("post_wd_tflag", timeout_flag, 1'b1);

    // mem_ready while idle is ignored
    spurious = 1'b1;
    check("spur_m0_ready", m0_ready, 1'b0);
    check("spur_m1_ready", m1_ready, 1'b0);
    step();
    spurious = 1'b0;
    check("spur_grant", grant, 2'b00);

    // reset during an m1 write
    ram_dead = 1'b1;
    r1 = rdy1_cnt;
    drive(1, 1'b1, 16'h0ABC, 16'h5555, 1'b0);
    step();
    check("rstb_grant", grant, 2'b10);
    step();
    rst = 1'b0;
    step();
    check("rstb_mem_we", mem_we, 1'b0);
    check("rstb_grant_idle", grant, 2'b00);
    check("rstb_tflag", timeout_flag, 1'b0);
    check("rstb_m1_ready", m1_ready, 1'b0);
    rst = 1'b1;
    release_m(1);
    ram_dead = 1'b0;
    step();
    check("rstb_m1_pulses", rdy1_cnt - r1, 0);

    // final report
    check("sb0_drained", exp_q0.size(), 0);
    check("sb1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single RAM2 memory port between two requesters: master 0 (rcpu) and master 1 (DMA/debug loader).
- Sits between the requesters and RAM2.
- Each side uses the same addr/rdata/wdata/we/re/ready handshake as RAM2, so each master sees a private RAM port, stretched by arbitration wait.
- Includes a hang watchdog that completes a transaction when RAM never answers.

Parameters:
AW, 16, address width on all ports
DW, 16, data width on all ports
TIMEOUT, 255, max BUSY cycles before watchdog abort; 0 disables watchdog
CW, 8, watchdog counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
m0_addr  input  AW  master 0 address
m0_wdata  input  DW  master 0 write data
m0_we  input  1  master 0 write request
m0_re  input  1  master 0 read request
m0_rdata  output  DW  master 0 read data
m0_ready  output  1  master 0 completion pulse
m1_addr, m1_wdata, m1_we, m1_re, m1_rdata, m1_ready  same as m0_*, for master 1
mem_addr  output  AW  to RAM2 addr
mem_wdata  output  DW  to RAM2 wdata
mem_we  output  1  to RAM2 we
mem_re  output  1  to RAM2 re
mem_rdata  input  DW  from RAM2 rdata
mem_ready  input  1  from RAM2 ready
grant  output  2  one-hot current owner; 00 when idle
timeout_flag  output  1  sticky; set on any watchdog abort

Behaviour:
- Reset (rst==0 at rising edge):
  - state=IDLE, grant=00, counter=0, timeout_flag=0, last-winner=1 (so master 0 wins the first tie).
  - mem_we=mem_re=0; m0_ready=m1_ready=0.
- Master protocol:
  - Master raises re or we (never both) with addr/wdata, and holds them stable until it samples its ready=1.
  - Master drops re/we on the edge where it samples ready.
- FSM states: IDLE, BUSY.
- IDLE:
  - req_n = mn_re|mn_we.
  - No req: stay IDLE.
  - One req: register grant to that master; go to BUSY.
  - Both req: pick per the arbitration policy (see Optional Feature); go to BUSY.
  - Arbitration costs exactly 1 cycle.
  - In IDLE, mem_we=mem_re=0; mem_addr/mem_wdata are don't-care but driven from master 0.
- BUSY:
  - mem_addr/wdata/we/re are combinationally muxed from the granted master.
  - Counter increments each BUSY cycle.
  - On mem_ready=1: granted mn_ready=1 combinationally for that cycle; next state IDLE; counter cleared; last-winner updated.
- Read data:
  - m0_rdata and m1_rdata are both wired directly to mem_rdata.
  - Only the master whose ready pulses may sample it.
- Latency: request-to-ready = 1 arbitration cycle + RAM latency. Back-to-back requests from the same master are separated by ≥1 IDLE cycle.
- Ungranted master: ready held 0 and its request is ignored. It keeps waiting; no request loss.
- Watchdog:
  - Condition: TIMEOUT!=0, counter reaches TIMEOUT, and mem_ready still 0.
  - Action: force mn_ready=1 to the granted master that cycle; deassert mem_we/re; go to IDLE; set timeout_flag.
  - Read data on an abort is undefined.
- Simultaneous mem_ready and timeout in the same cycle: treat as normal completion; timeout_flag not set.
- mem_ready while IDLE: ignored; no master ready asserted.
- Reset mid-BUSY: abandons the transaction immediately. Next cycle mem_we/re=0 and grant=00; the master re-requests.
- Master drops request while BUSY (protocol violation): arbiter stays BUSY until mem_ready or timeout.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant goes to the master that did NOT win the last completed transaction (last-winner register, reset value 1).
- Undefined: fixed priority; master 0 (CPU) always wins ties. The last-winner register is not synthesized. Master 1 may starve under continuous CPU traffic.

Test Plan:
- Single read: preload RAM[0x0010]=0xBEEF; m0 read 0x0010 → grant=01 one cycle later, mem_re=1, m0_ready pulses once, m0_rdata=0xBEEF, m1_ready stays 0.
- Single write then read: m1 writes 0x1234 to 0xCFF0, then m0 reads 0xCFF0 → m0_rdata=0x1234; grant sequence 10, 00, 01.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined: both masters read continuously for 4 transactions → grants alternate 01, 10, 01, 10.
- Same simultaneous requests, macro undefined → grant=01 every time; m1_ready never pulses.
- Watchdog: TIMEOUT=4 with a RAM model that never readies; m0 read → m0_ready pulses exactly 4 BUSY cycles after grant, timeout_flag=1, state returns to IDLE. A later normal m1 read completes correctly.
- Reset mid-BUSY: rst=0 for one cycle during an m1 write → next cycle mem_we=0, grant=00, timeout_flag=0, no ready pulse to m1.
